ps2_keyboard_rx: RTL and testbench

PS/2 keyboard receiver that feeds the `key_reg` byte consumed by the processor's memory-mapped `Memory` block. It synchronises the external PS/2 clock and data lines, deserialises 11-bit device-to-host frames, checks parity and framing, and queues received scan codes in a small first-word-fall-through FIFO. The processor reads the head byte through `key_reg` and retires it by pulsing `key_pop`.

---
 rtl/kbd_pkg.sv | 21 ++
 rtl/kbd_fifo.sv | 101 ++++++++++
 rtl/ps2_keyboard_rx.sv | 218 +++++++++++++++++++++
 tb/tb_ps2_keyboard_rx.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/kbd_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: frame FSM states,
// frame constants and the odd-parity helper.
package kbd_pkg;

   localparam int         PS2_DATA_BITS = 8;
   localparam logic [7:0] BREAK_CODE    = 8'hF0;
   localparam logic [7:0] EXT_CODE      = 8'hE0;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } kbd_state_t;

   // Returns 1 when the nine bits (eight data bits plus parity) have odd parity.
   function automatic logic odd_parity_ok(input logic [8:0] bits_9);
      return ^bits_9;
   endfunction

endpackage

// File: rtl/kbd_fifo.sv
// First-word-fall-through scan-code queue. The head byte and the
// not-empty flag are registered. A push into a full queue is dropped
// (drop pulses) unless a pop happens in the same cycle.
module kbd_fifo
   import kbd_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = PS2_DATA_BITS
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             not_empty,
   output logic             drop
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [PTR_W-1:0] PTR_ONE   = {{(PTR_W-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic [WIDTH-1:0] head_r;
   logic             valid_r;

   logic             pop_eff_s;
   logic             push_eff_s;
   logic             drop_s;
   logic [CNT_W-1:0] count_next_s;
   logic [WIDTH-1:0] head_next_s;

   // Decide which requests take effect and precompute the next head byte.
   always_comb begin
      pop_eff_s    = 1'b0;
      push_eff_s   = 1'b0;
      drop_s       = 1'b0;
      count_next_s = count_r;
      head_next_s  = head_r;

      pop_eff_s  = pop && (count_r != '0);
      push_eff_s = push && ((count_r != DEPTH_CNT) || pop_eff_s);
      drop_s     = push && !push_eff_s;

      case ({push_eff_s, pop_eff_s})
         2'b10:   count_next_s = count_r + CNT_ONE;
         2'b01:   count_next_s = count_r - CNT_ONE;
         default: count_next_s = count_r;
      endcase

      if (count_next_s == '0) begin
         head_next_s = '0;
      end else if ((count_r == '0) || (pop_eff_s && (count_r == CNT_ONE))) begin
         // the pushed byte becomes the head straight away
         head_next_s = push_data;
      end else if (pop_eff_s) begin
         head_next_s = mem_r[rd_ptr_r + PTR_ONE];
      end else begin
         head_next_s = head_r;
      end
   end

   // Pointers, occupancy and registered head/valid outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
         head_r   <= '0;
         valid_r  <= 1'b0;
      end else begin
         if (push_eff_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_eff_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         count_r <= count_next_s;
         head_r  <= head_next_s;
         valid_r <= (count_next_s != '0);
      end
   end

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (push_eff_s) begin
         mem_r[wr_ptr_r] <= push_data;
      end
   end

   assign head_data = head_r;
   assign not_empty = valid_r;
   assign drop      = drop_s;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronises ps2_clk/ps2_data, decodes 11-bit
// device-to-host frames on synced falling edges, checks parity/stop bit,
// abandons stalled frames after TIMEOUT_CYCLES and queues good bytes.
// Optional build macro KBD_BREAK_FILTER_EN: drops 0xF0 and the byte
// following it so only make codes reach the queue.
module ps2_keyboard_rx
   import kbd_pkg::*;
#(
   parameter int FIFO_DEPTH     = 4,
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       key_pop,
   input  logic       err_clr,
   output logic [7:0] key_reg,
   output logic       key_valid,
   output logic       frame_err,
   output logic       overflow
);

   localparam int BIT_W = $clog2(PS2_DATA_BITS);
   localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PS2_DATA_BITS - 1);
   localparam logic [BIT_W-1:0] BIT_ONE  = {{(BIT_W-1){1'b0}}, 1'b1};
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TO_W-1:0]  TO_ONE   = {{(TO_W-1){1'b0}}, 1'b1};

   logic [SYNC_STAGES-1:0] clk_sync_r;
   logic [SYNC_STAGES-1:0] data_sync_r;
   logic                   clk_prev_r;
   logic                   ps2_clk_s;
   logic                   data_s;
   logic                   fall_s;

   kbd_state_t             state_r, state_next_s;
   logic [BIT_W-1:0]       bit_cnt_r, bit_cnt_next_s;
   logic [7:0]             shreg_r, shreg_next_s;
   logic                   par_ok_r, par_ok_next_s;
   logic [TO_W-1:0]        to_cnt_r, to_cnt_next_s;
   logic                   good_s;
   logic                   err_set_s;
   logic                   push_s;
   logic                   drop_s;
   logic                   frame_err_r;
   logic                   overflow_r;

   // Metastability synchronisers; idle PS/2 lines are high.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         clk_sync_r  <= '1;
         data_sync_r <= '1;
         clk_prev_r  <= 1'b1;
      end else begin
         clk_sync_r  <= {clk_sync_r[SYNC_STAGES-2:0], ps2_clk};
         data_sync_r <= {data_sync_r[SYNC_STAGES-2:0], ps2_data};
         clk_prev_r  <= ps2_clk_s;
      end
   end

   assign ps2_clk_s = clk_sync_r[SYNC_STAGES-1];
   assign data_s    = data_sync_r[SYNC_STAGES-1];
   assign fall_s    = clk_prev_r & ~ps2_clk_s;

   // Frame FSM next state, bit shifting and the stall timeout.
   always_comb begin
      state_next_s   = state_r;
      bit_cnt_next_s = bit_cnt_r;
      shreg_next_s   = shreg_r;
      par_ok_next_s  = par_ok_r;
      to_cnt_next_s  = to_cnt_r;
      good_s         = 1'b0;
      err_set_s      = 1'b0;

      if (state_r == ST_IDLE) begin
         to_cnt_next_s = '0;
      end else if (fall_s) begin
         to_cnt_next_s = '0;
      end else begin
         to_cnt_next_s = to_cnt_r + TO_ONE;
      end

      if ((state_r != ST_IDLE) && !fall_s && (to_cnt_r == TO_LAST)) begin
         // device stopped clocking mid-frame
         state_next_s  = ST_IDLE;
         to_cnt_next_s = '0;
         err_set_s     = 1'b1;
      end else if (fall_s) begin
         case (state_r)
            ST_IDLE: begin
               if (!data_s) begin
                  bit_cnt_next_s = '0;
                  state_next_s   = ST_DATA;
               end else begin
                  state_next_s   = ST_IDLE;
               end
            end
            ST_DATA: begin
               shreg_next_s = {data_s, shreg_r[7:1]};
               if (bit_cnt_r == BIT_LAST) begin
                  bit_cnt_next_s = '0;
                  state_next_s   = ST_PARITY;
               end else begin
                  bit_cnt_next_s = bit_cnt_r + BIT_ONE;
               end
            end
            ST_PARITY: begin
               par_ok_next_s = odd_parity_ok({shreg_r, data_s});
               state_next_s  = ST_STOP;
            end
            ST_STOP: begin
               if (data_s && par_ok_r) begin
                  good_s    = 1'b1;
               end else begin
                  err_set_s = 1'b1;
               end
               state_next_s = ST_IDLE;
            end
            default: begin
               state_next_s = ST_IDLE;
            end
         endcase
      end else begin
         state_next_s = state_r;
      end
   end

   // Frame FSM state and datapath registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r   <= ST_IDLE;
         bit_cnt_r <= '0;
         shreg_r   <= '0;
         par_ok_r  <= 1'b0;
         to_cnt_r  <= '0;
      end else begin
         state_r   <= state_next_s;
         bit_cnt_r <= bit_cnt_next_s;
         shreg_r   <= shreg_next_s;
         par_ok_r  <= par_ok_next_s;
         to_cnt_r  <= to_cnt_next_s;
      end
   end

`ifdef KBD_BREAK_FILTER_EN
   logic break_pending_r, break_pending_next_s;

   // Suppress 0xF0 and the byte after it; 0xE0 is treated like any other byte.
   always_comb begin
      push_s               = 1'b0;
      break_pending_next_s = break_pending_r;
      if (err_set_s) begin
         break_pending_next_s = 1'b0;
      end else if (good_s) begin
         if (shreg_r == BREAK_CODE) begin
            break_pending_next_s = 1'b1;
         end else if (break_pending_r) begin
            break_pending_next_s = 1'b0;
         end else begin
            push_s = 1'b1;
         end
      end else begin
         break_pending_next_s = break_pending_r;
      end
   end

   // Break-pending flag register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         break_pending_r <= 1'b0;
      end else begin
         break_pending_r <= break_pending_next_s;
      end
   end
`else
   assign push_s = good_s;
`endif

   kbd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (PS2_DATA_BITS)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push_s),
      .push_data (shreg_r),
      .pop       (key_pop),
      .head_data (key_reg),
      .not_empty (key_valid),
      .drop      (drop_s)
   );

   // Sticky error flags; a new error in the clearing cycle wins.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         frame_err_r <= 1'b0;
         overflow_r  <= 1'b0;
      end else begin
         if (err_set_s) begin
            frame_err_r <= 1'b1;
         end else if (err_clr) begin
            frame_err_r <= 1'b0;
         end
         if (drop_s) begin
            overflow_r <= 1'b1;
         end else if (err_clr) begin
            overflow_r <= 1'b0;
         end
      end
   end

   assign frame_err = frame_err_r;
   assign overflow  = overflow_r;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Scoreboard bench for ps2_keyboard_rx: expected bytes are queued as
// frames are driven and compared as the DUT presents them.
module tb_ps2_keyboard_rx;

   localparam int DEPTH = 4;
   localparam int SYNC  = 2;
   localparam int TMO   = 200;
   localparam int HALF  = 8;

   logic       clk      = 1'b0;
   logic       reset    = 1'b0;
   logic       ps2_clk  = 1'b1;
   logic       ps2_data = 1'b1;
   logic       key_pop  = 1'b0;
   logic       err_clr  = 1'b0;
   logic [7:0] key_reg;
   logic       key_valid;
   logic       frame_err;
   logic       overflow;

   int         tests_run    = 0;
   int         tests_failed = 0;
   logic [7:0] exp_q[$];
   logic       exp_ferr = 1'b0;
   logic       exp_ovf  = 1'b0;
   logic       exp_brk  = 1'b0;

   always #5 clk = ~clk;

   ps2_keyboard_rx #(
      .FIFO_DEPTH     (DEPTH),
      .SYNC_STAGES    (SYNC),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .key_pop   (key_pop),
      .err_clr   (err_clr),
      .key_reg   (key_reg),
      .key_valid (key_valid),
      .frame_err (frame_err),
      .overflow  (overflow)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [10:0] make_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
      logic par;
      par = ~(^b) ^ bad_par;
      return {~bad_stop, par, b, 1'b0};
   endfunction

   // Drive the first nbits of a frame; optionally time the push after the stop fall.
   task automatic send_bits(input logic [10:0] bits, input int nbits, input bit meas);
      int lat;
      for (int i = 0; i < nbits; i++) begin
         ps2_data = bits[i];
         wait_cyc(HALF);
         ps2_clk = 1'b0;
         if (meas && (i == 10)) begin
            lat = 0;
            while (!key_valid && (lat < SYNC + 2)) begin
               @(negedge clk);
               lat++;
            end
            check_eq("push_latency", lat, SYNC + 1);
            wait_cyc(HALF - lat);
         end else begin
            wait_cyc(HALF);
         end
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
      wait_cyc(HALF);
   endtask

   // Reference behaviour for one complete frame.
   task automatic model_frame(input logic [7:0] b, input bit bad);
      if (bad) begin
         exp_ferr = 1'b1;
         exp_brk  = 1'b0;
      end else begin
`ifdef KBD_BREAK_FILTER_EN
         if (b == 8'hF0) begin
            exp_brk = 1'b1;
         end else if (exp_brk) begin
            exp_brk = 1'b0;
         end else if (exp_q.size() < DEPTH) begin
            exp_q.push_back(b);
         end else begin
            exp_ovf = 1'b1;
         end
`else
         if (exp_q.size() < DEPTH) begin
            exp_q.push_back(b);
         end else begin
            exp_ovf = 1'b1;
         end
`endif
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input bit meas);
      send_bits(make_frame(b, bad_par, bad_stop), 11, meas);
      model_frame(b, bad_par | bad_stop);
      check_eq("frame_err", frame_err, exp_ferr);
      check_eq("overflow", overflow, exp_ovf);
      check_eq("valid", key_valid, exp_q.size() != 0);
   endtask

   task automatic pop_one();
      logic [7:0] e;
      e = exp_q.pop_front();
      check_eq("head_valid", key_valid, 1'b1);
      check_eq("head", key_reg, e);
      key_pop = 1'b1;
      @(negedge clk);
      key_pop = 1'b0;
      check_eq("pop_valid", key_valid, exp_q.size() != 0);
      if (exp_q.size() == 0) begin
         check_eq("pop_reg_empty", key_reg, 8'h00);
      end else begin
         check_eq("pop_reg_next", key_reg, exp_q[0]);
      end
   endtask

   task automatic drain();
      int budget;
      budget = 0;
      while ((exp_q.size() > 0) && (budget < DEPTH + 2)) begin
         pop_one();
         budget++;
      end
      check_eq("drained_valid", key_valid, 1'b0);
      check_eq("drained_reg", key_reg, 8'h00);
   endtask

   task automatic clear_errors();
      err_clr = 1'b1;
      @(negedge clk);
      err_clr  = 1'b0;
      exp_ferr = 1'b0;
      exp_ovf  = 1'b0;
      check_eq("clr_frame_err", frame_err, exp_ferr);
      check_eq("clr_overflow", overflow, exp_ovf);
   endtask

   // Global time bound so a stuck design cannot hang the run.
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   // Main stimulus sequence.
   initial begin
      wait_cyc(4);
      check_eq("rst_key_reg", key_reg, 8'h00);
      check_eq("rst_valid", key_valid, 1'b0);
      check_eq("rst_frame_err", frame_err, 1'b0);
      check_eq("rst_overflow", overflow, 1'b0);
      reset = 1'b1;
      wait_cyc(4);

      // single good frame with push latency measurement
      send_frame(8'h1C, 1'b0, 1'b0, 1'b1);
      drain();

      // pop while empty is ignored
      key_pop = 1'b1;
      @(negedge clk);
      key_pop = 1'b0;
      check_eq("empty_pop_valid", key_valid, 1'b0);
      check_eq("empty_pop_reg", key_reg, 8'h00);

      // parity and stop-bit errors
      send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
      clear_errors();
      send_frame(8'h2A, 1'b0, 1'b1, 1'b0);
      clear_errors();

      // overflow: five frames into a depth-4 queue
      send_frame(8'h16, 1'b0, 1'b0, 1'b0);
      send_frame(8'h1E, 1'b0, 1'b0, 1'b0);
      send_frame(8'h26, 1'b0, 1'b0, 1'b0);
      send_frame(8'h25, 1'b0, 1'b0, 1'b0);
      send_frame(8'h2E, 1'b0, 1'b0, 1'b0);
      drain();
      clear_errors();

      // timeout on a stalled partial frame
      send_bits(make_frame(8'h5A, 1'b0, 1'b0), 4, 1'b0);
      wait_cyc(TMO / 2 - 2 * HALF);
      check_eq("pre_timeout_err", frame_err, 1'b0);
      wait_cyc(TMO / 2 + 10);
      exp_ferr = 1'b1;
      exp_brk  = 1'b0;
      check_eq("timeout_err", frame_err, exp_ferr);
      clear_errors();
      send_frame(8'h32, 1'b0, 1'b0, 1'b0);
      drain();

      // break code and extended prefix
      send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
      send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
      send_frame(8'hE0, 1'b0, 1'b0, 1'b0);
      send_frame(8'h74, 1'b0, 1'b0, 1'b0);
      drain();

      // reset mid-frame with bytes queued and an error flagged
      send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
      send_frame(8'h32, 1'b0, 1'b0, 1'b0);
      send_frame(8'h11, 1'b1, 1'b0, 1'b0);
      send_bits(make_frame(8'h45, 1'b0, 1'b0), 5, 1'b0);
      reset = 1'b0;
      wait_cyc(3);
      exp_q.delete();
      exp_ferr = 1'b0;
      exp_ovf  = 1'b0;
      exp_brk  = 1'b0;
      check_eq("mid_rst_valid", key_valid, 1'b0);
      check_eq("mid_rst_reg", key_reg, 8'h00);
      check_eq("mid_rst_frame_err", frame_err, exp_ferr);
      check_eq("mid_rst_overflow", overflow, exp_ovf);
      reset = 1'b1;
      wait_cyc(4);
      send_frame(8'h45, 1'b0, 1'b0, 1'b0);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
